// File: rtl/pkg_parameters.sv
// ---------------------------------------------------------------------------
// pkg_parameters
// Shared constants and types for the dense (fully connected) layer.
//   FEATURE_MAP_RESOLUTION : bit width of signed data, weight, bias and result words
//   DENSE_WEIGHTS_ADDRWIDE : width of the external weight memory address
//   dense_state_t          : sequencing states of dense_layer
// ---------------------------------------------------------------------------
package pkg_parameters;

    localparam int FEATURE_MAP_RESOLUTION = 8;
    localparam int DENSE_WEIGHTS_ADDRWIDE = 10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        DRAIN     = 2'd2,
        OUT_VALID = 2'd3
    } dense_state_t;

endpackage

// File: rtl/dense_mac.sv
// ---------------------------------------------------------------------------
// dense_mac
// Multiply-accumulate for one output neuron, followed by fixed-point
// rescaling (arithmetic shift right, truncating) and saturation.
//
// Optional feature: `define DENSE_RELU_EN to clamp negative results to 0.
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, clears the accumulator
//   mac_en  : accumulate data * weight this cycle
//   bias_en : weight carries the bias; result includes bias << FRAC_BITS
//   clear   : synchronous accumulator clear (end of a neuron)
//   data    : signed input element
//   weight  : signed weight or bias word
//   result  : rescaled, saturated neuron output (combinational)
// ---------------------------------------------------------------------------
module dense_mac
    import pkg_parameters::*;
#(
    parameter int IN_SIZE   = 40,
    parameter int FRAC_BITS = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     mac_en,
    input  logic                                     bias_en,
    input  logic                                     clear,
    input  logic signed [FEATURE_MAP_RESOLUTION-1:0] data,
    input  logic signed [FEATURE_MAP_RESOLUTION-1:0] weight,
    output logic signed [FEATURE_MAP_RESOLUTION-1:0] result
);

    localparam int R     = FEATURE_MAP_RESOLUTION;
    localparam int ACC_W = 2 * R + $clog2(IN_SIZE) + 1;

    // One guard bit above the accumulator so the bias add cannot wrap.
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(2 ** (R - 1) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - 1;

    logic signed [ACC_W-1:0] acc_reg;
    logic signed [2*R-1:0]   product;
    logic signed [ACC_W:0]   bias_term;
    logic signed [ACC_W:0]   sum_full;
    logic signed [ACC_W:0]   shifted;
    logic signed [R-1:0]     sat_value;

    assign product = data * weight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else if (mac_en) begin
            acc_reg <= acc_reg + ACC_W'(product);
        end
    end

    // The bias word arrives on the same cycle the result is consumed, so it
    // is folded in combinationally rather than through the accumulator.
    always_comb begin
        bias_term = '0;
        if (bias_en) begin
            bias_term = (ACC_W + 1)'(weight) <<< FRAC_BITS;
        end
        sum_full = (ACC_W + 1)'(acc_reg) + bias_term;
        shifted  = sum_full >>> FRAC_BITS;
    end

    always_comb begin
        if (shifted > SAT_MAX) begin
            sat_value = SAT_MAX[R-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_value = SAT_MIN[R-1:0];
        end else begin
            sat_value = shifted[R-1:0];
        end
    end

`ifdef DENSE_RELU_EN
    assign result = sat_value[R-1] ? '0 : sat_value;
`else
    assign result = sat_value;
`endif

endmodule

// File: rtl/dense_layer.sv
// ---------------------------------------------------------------------------
// dense_layer
// Fully connected layer. Registers a flattened input vector, then for each
// output neuron j streams weights j*(IN+1)+0..IN-1 and the bias at
// j*(IN+1)+IN from an external memory with one-cycle read latency, and
// stores the rescaled neuron result. The full result vector is presented
// with valid/ready until accepted.
//
// Optional feature: `define DENSE_RELU_EN (applied inside dense_mac).
//
// Ports
//   clk_i           : clock, rising edge
//   rst_i           : asynchronous active-high reset
//   flatten_valid_i : input vector valid
//   flatten_data_i  : signed input vector [DENSE_IN_SIZE]
//   flatten_ready_o : block idle and able to accept a vector
//   weight_addr_o   : weight memory read address (0 when not fetching)
//   weight_data_i   : weight/bias word, one cycle after its address
//   dense_valid_o   : result vector valid
//   dense_data_o    : signed result vector [DENSE_OUT_SIZE]
//   dense_ready_i   : downstream accepts the result
// ---------------------------------------------------------------------------
module dense_layer
    import pkg_parameters::*;
#(
    parameter int DENSE_IN_SIZE  = 40,
    parameter int DENSE_OUT_SIZE = 10,
    parameter int FRAC_BITS      = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     flatten_valid_i,
    input  logic signed [FEATURE_MAP_RESOLUTION-1:0] flatten_data_i [DENSE_IN_SIZE],
    output logic                                     flatten_ready_o,
    output logic        [DENSE_WEIGHTS_ADDRWIDE-1:0] weight_addr_o,
    input  logic signed [FEATURE_MAP_RESOLUTION-1:0] weight_data_i,
    output logic                                     dense_valid_o,
    output logic signed [FEATURE_MAP_RESOLUTION-1:0] dense_data_o [DENSE_OUT_SIZE],
    input  logic                                     dense_ready_i
);

    localparam int R   = FEATURE_MAP_RESOLUTION;
    localparam int AW  = DENSE_WEIGHTS_ADDRWIDE;
    localparam int I_W = $clog2(DENSE_IN_SIZE + 1);
    localparam int J_W = (DENSE_OUT_SIZE > 1) ? $clog2(DENSE_OUT_SIZE) : 1;

    localparam logic [I_W-1:0] I_LAST     = I_W'(DENSE_IN_SIZE);
    localparam logic [J_W-1:0] J_LAST     = J_W'(DENSE_OUT_SIZE - 1);
    localparam logic [AW-1:0]  ROW_STRIDE = AW'(DENSE_IN_SIZE + 1);

    dense_state_t state_reg;
    dense_state_t state_next;

    logic signed [R-1:0] x_reg [DENSE_IN_SIZE];
    logic [I_W-1:0]      i_reg;
    logic [J_W-1:0]      j_reg;
    logic [AW-1:0]       base_reg;        // j * (DENSE_IN_SIZE + 1)
    logic                data_valid_reg;  // weight_data_i holds a requested word
    logic [I_W-1:0]      idx_reg;         // element index of that word
    logic signed [R-1:0] x_sel;
    logic signed [R-1:0] mac_result;
    logic                accept;

    assign accept = flatten_valid_i && flatten_ready_o;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (accept) state_next = FETCH;
            FETCH:     if (i_reg == I_LAST) state_next = DRAIN;
            DRAIN:     state_next = (j_reg == J_LAST) ? OUT_VALID : FETCH;
            OUT_VALID: if (dense_ready_i) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        flatten_ready_o = (state_reg == IDLE) && !rst_i;
        dense_valid_o   = (state_reg == OUT_VALID);
        weight_addr_o   = '0;
        if (state_reg == FETCH) begin
            weight_addr_o = base_reg + AW'(i_reg);
        end
    end

    // ---------------- counters and input capture ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < DENSE_IN_SIZE; k++) begin
                x_reg[k] <= '0;
            end
            i_reg          <= '0;
            j_reg          <= '0;
            base_reg       <= '0;
            data_valid_reg <= 1'b0;
            idx_reg        <= '0;
        end else begin
            data_valid_reg <= (state_reg == FETCH);
            idx_reg        <= i_reg;
            case (state_reg)
                IDLE: begin
                    // Only captured here, so a vector offered mid-computation
                    // cannot disturb the operands in use.
                    if (accept) begin
                        x_reg    <= flatten_data_i;
                        i_reg    <= '0;
                        j_reg    <= '0;
                        base_reg <= '0;
                    end
                end
                FETCH: begin
                    i_reg <= (i_reg == I_LAST) ? '0 : i_reg + 1'b1;
                end
                DRAIN: begin
                    j_reg    <= j_reg + 1'b1;
                    base_reg <= base_reg + ROW_STRIDE;
                end
                default: ;
            endcase
        end
    end

    // Input element that pairs with the weight now on weight_data_i.
    always_comb begin
        x_sel = '0;
        for (int k = 0; k < DENSE_IN_SIZE; k++) begin
            if (idx_reg == I_W'(k)) begin
                x_sel = x_reg[k];
            end
        end
    end

    dense_mac #(
        .IN_SIZE   (DENSE_IN_SIZE),
        .FRAC_BITS (FRAC_BITS)
    ) u_mac (
        .clk     (clk_i),
        .rst     (rst_i),
        .mac_en  (data_valid_reg && (idx_reg != I_LAST)),
        .bias_en (data_valid_reg && (idx_reg == I_LAST)),
        .clear   (state_reg == DRAIN),
        .data    (x_sel),
        .weight  (weight_data_i),
        .result  (mac_result)
    );

    // ---------------- result slots ----------------
    for (genvar gi = 0; gi < DENSE_OUT_SIZE; gi++) begin : g_slot
        logic signed [R-1:0] slot_reg;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                slot_reg <= '0;
            end else if ((state_reg == DRAIN) && (j_reg == J_W'(gi))) begin
                slot_reg <= mac_result;
            end
        end

        assign dense_data_o[gi] = slot_reg;
    end

endmodule

// File: tb/tb_dense_layer.sv
// ---------------------------------------------------------------------------
// tb_dense_layer
// Directed bench for dense_layer with IN=4, OUT=2, 8-bit data, FRAC_BITS=4.
// The weight memory is modelled as a registered read (one-cycle latency).
// Honours `define DENSE_RELU_EN for the expected negative results.
// ---------------------------------------------------------------------------
module tb_dense_layer;
    import pkg_parameters::*;

    localparam int IN  = 4;
    localparam int OUT = 2;
    localparam int FB  = 4;
    localparam int R   = FEATURE_MAP_RESOLUTION;
    localparam int AW  = DENSE_WEIGHTS_ADDRWIDE;

`ifdef DENSE_RELU_EN
    localparam int NEG_SAT = 0;
    localparam int NEG_MIX = 0;
`else
    localparam int NEG_SAT = -128;
    localparam int NEG_MIX = -28;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                flatten_valid;
    logic signed [R-1:0] flatten_data [IN];
    logic                flatten_ready;
    logic [AW-1:0]       weight_addr;
    logic signed [R-1:0] weight_data;
    logic                dense_valid;
    logic signed [R-1:0] dense_data [OUT];
    logic                dense_ready;

    logic signed [R-1:0] wmem [16];
    int n_cmp = 0;
    int n_bad = 0;
    // Expected address at cycle k after the handshake (index 0 unused).
    int exp_addr [14] = '{0, 0, 1, 2, 3, 4, 0, 5, 6, 7, 8, 9, 0, 0};

    dense_layer #(
        .DENSE_IN_SIZE  (IN),
        .DENSE_OUT_SIZE (OUT),
        .FRAC_BITS      (FB)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flatten_valid_i (flatten_valid),
        .flatten_data_i  (flatten_data),
        .flatten_ready_o (flatten_ready),
        .weight_addr_o   (weight_addr),
        .weight_data_i   (weight_data),
        .dense_valid_o   (dense_valid),
        .dense_data_o    (dense_data),
        .dense_ready_i   (dense_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        weight_data <= (weight_addr < AW'(16)) ? wmem[weight_addr[3:0]] : '0;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic set_x(input int a, input int b, input int c, input int d);
        flatten_data[0] = R'(a);
        flatten_data[1] = R'(b);
        flatten_data[2] = R'(c);
        flatten_data[3] = R'(d);
    endtask

    task automatic fill_mem(input int w, input int bias);
        for (int a = 0; a < 16; a++) wmem[a] = R'(w);
        wmem[4] = R'(bias);
        wmem[9] = R'(bias);
    endtask

    // Called just after a negedge with the block idle; returns just after a
    // negedge with the block idle again.
    task automatic run_vector(input string tag, input bit full_addr, input bit garble,
                              input int stall, input int exp0, input int exp1);
        check({tag, "_ready_idle"}, flatten_ready, 1);
        flatten_valid = 1'b1;
        @(negedge clk);
        flatten_valid = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (garble && k == 2) begin
                flatten_valid = 1'b1;
                set_x(-100, -100, -100, -100);
            end
            if (garble && k == 10) flatten_valid = 1'b0;
            if (full_addr) check($sformatf("%s_addr_c%0d", tag, k), weight_addr, exp_addr[k]);
            if (full_addr || k >= 12)
                check($sformatf("%s_valid_c%0d", tag, k), dense_valid, (k == 13) ? 1 : 0);
            if (k < 13) @(negedge clk);
        end
        check({tag, "_data0"}, dense_data[0], exp0);
        check({tag, "_data1"}, dense_data[1], exp1);
        check({tag, "_ready_busy"}, flatten_ready, 0);
        for (int s = 1; s <= stall; s++) begin
            flatten_valid = 1'b1;
            @(negedge clk);
            check($sformatf("%s_hold_valid%0d", tag, s), dense_valid, 1);
            check($sformatf("%s_hold_data0_%0d", tag, s), dense_data[0], exp0);
            check($sformatf("%s_hold_data1_%0d", tag, s), dense_data[1], exp1);
            check($sformatf("%s_hold_ready%0d", tag, s), flatten_ready, 0);
        end
        flatten_valid = 1'b0;
        dense_ready   = 1'b1;
        @(negedge clk);
        dense_ready = 1'b0;
        check({tag, "_valid_after"}, dense_valid, 0);
        check({tag, "_ready_after"}, flatten_ready, 1);
        $display("txn %s: out0=%0d out1=%0d", tag, dense_data[0], dense_data[1]);
    endtask

    initial begin
        bit seen_valid;
        rst           = 1'b1;
        flatten_valid = 1'b0;
        dense_ready   = 1'b0;
        set_x(0, 0, 0, 0);
        fill_mem(16, 0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", flatten_ready, 0);
        check("rst_valid", dense_valid, 0);
        check("rst_addr", weight_addr, 0);
        check("rst_data0", dense_data[0], 0);
        check("rst_data1", dense_data[1], 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", flatten_ready, 1);

        // 1.0 * 1.0 summed over 4 elements -> 4.0 = 64, with address sequence
        set_x(16, 16, 16, 16);
        fill_mem(16, 0);
        run_vector("unity", 1'b1, 1'b0, 0, 64, 64);

        // Positive saturation
        set_x(127, 127, 127, 127);
        fill_mem(127, 127);
        run_vector("sat_pos", 1'b0, 1'b0, 0, 127, 127);

        // Negative saturation (or ReLU clamp)
        fill_mem(-128, -128);
        run_vector("sat_neg", 1'b0, 1'b0, 0, NEG_SAT, NEG_SAT);

        // Mixed signs, truncating shift; input toggled mid-compute must be ignored
        // n0: (256-512+128+784+256)>>>4 = 57 ; n1: (-256-256+0+196-128)>>>4 = -28
        set_x(16, -32, 8, 49);
        fill_mem(16, 16);
        wmem[5] = -8'sd16; wmem[6] = 8'sd8; wmem[7] = 8'sd0; wmem[8] = 8'sd4; wmem[9] = -8'sd8;
        run_vector("mixed", 1'b0, 1'b1, 0, 57, NEG_MIX);

        // Back-pressure: 5 cycles held in OUT_VALID with a competing input
        set_x(16, 16, 16, 16);
        fill_mem(16, 0);
        run_vector("stall", 1'b0, 1'b0, 5, 64, 64);

        // Reset mid-FETCH
        set_x(16, -32, 8, 49);
        fill_mem(16, 16);
        wmem[5] = -8'sd16; wmem[6] = 8'sd8; wmem[7] = 8'sd0; wmem[8] = 8'sd4; wmem[9] = -8'sd8;
        flatten_valid = 1'b1;
        @(negedge clk);
        flatten_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_addr_before", weight_addr, 2);
        rst = 1'b1;
        #1;
        check("midrst_addr", weight_addr, 0);
        check("midrst_valid", dense_valid, 0);
        check("midrst_ready", flatten_ready, 0);
        check("midrst_data0", dense_data[0], 0);
        check("midrst_data1", dense_data[1], 0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dense_valid) seen_valid = 1'b1;
        end
        check("midrst_no_pulse", seen_valid, 0);
        run_vector("after_rst", 1'b0, 1'b0, 0, 57, NEG_MIX);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
